// File: rtl/latency_bram_ctrl.sv
// rtl/latency_bram_ctrl.sv - timestamp BRAM controller measuring TX-to-RX echo latency
`timescale 1ns/1ps
module latency_bram_ctrl #(
    parameter int DEPTH_LOG2 = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [47:0]           latency_counter,
    input  logic                  stats_clear,
    input  logic                  tx_pkt_sent,
    input  logic                  rx_pkt_rcvd,
    output logic                  bram_wea,
    output logic [DEPTH_LOG2-1:0] bram_wr_addr,
    output logic [47:0]           bram_wr_data,
    output logic                  bram_reb,
    output logic [DEPTH_LOG2-1:0] bram_rd_addr,
    output logic                  bram_rstb,
    input  logic [47:0]           bram_rd_data,
    output logic [DEPTH_LOG2:0]   outstanding,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic                  lat_valid,
    output logic [47:0]           lat_value,
    output logic [47:0]           lat_min,
    output logic [47:0]           lat_max,
    output logic [63:0]           lat_sum,
    output logic [31:0]           lat_count
);

    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   readable;
    logic                  clear;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  rd_v1;
    logic                  rd_v2;
    logic [47:0]           ts_d1;
    logic [47:0]           ts_d2;
    logic [47:0]           diff;

    // An entry still sitting in the write register is not yet in the BRAM.
    always_comb begin
        clear    = rst | stats_clear;
        readable = outstanding - {{DEPTH_LOG2{1'b0}}, bram_wea};
        wr_ok    = tx_pkt_sent && (outstanding != FULL);
        rd_ok    = rx_pkt_rcvd && (readable != '0);
        diff     = ts_d2 - bram_rd_data;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding   <= '0;
            bram_wea      <= 1'b0;
            bram_wr_addr  <= '0;
            bram_wr_data  <= '0;
            bram_reb      <= 1'b0;
            bram_rd_addr  <= '0;
            bram_rstb     <= stats_clear;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            rd_v1         <= 1'b0;
            rd_v2         <= 1'b0;
            ts_d1         <= '0;
            ts_d2         <= '0;
            lat_valid     <= 1'b0;
            lat_value     <= '0;
            lat_min       <= '1;
            lat_max       <= '0;
            lat_sum       <= '0;
            lat_count     <= '0;
        end else begin
            bram_rstb <= 1'b0;
            bram_wea  <= wr_ok;
            if (wr_ok) begin
                bram_wr_addr <= wr_ptr;
                bram_wr_data <= latency_counter;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (tx_pkt_sent && !wr_ok)
                overflow_err <= 1'b1;

            bram_reb <= rd_ok;
            if (rd_ok) begin
                bram_rd_addr <= rd_ptr;
                rd_ptr       <= rd_ptr + 1'b1;
                ts_d1        <= latency_counter;
            end
            if (rx_pkt_rcvd && !rd_ok)
                underflow_err <= 1'b1;

            if (wr_ok && !rd_ok)
                outstanding <= outstanding + 1'b1;
            else if (rd_ok && !wr_ok)
                outstanding <= outstanding - 1'b1;

            // Valid/timestamp travel alongside the BRAM read so they meet its data.
            rd_v1     <= rd_ok;
            rd_v2     <= rd_v1;
            ts_d2     <= ts_d1;
            lat_valid <= rd_v2;
            if (rd_v2) begin
                lat_value <= diff;
                lat_sum   <= lat_sum + {16'b0, diff};
                if (lat_count != '1)
                    lat_count <= lat_count + 1'b1;
                if (diff < lat_min)
                    lat_min <= diff;
                if (diff > lat_max)
                    lat_max <= diff;
            end
        end
    end

endmodule

// File: tb/tb_latency_bram_ctrl.sv
// tb/tb_latency_bram_ctrl.sv - self-checking bench for latency_bram_ctrl
`timescale 1ns/1ps
module tb_latency_bram_ctrl;

    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] latency_counter = '0;
    logic        stats_clear = 1'b0;
    logic        tx_pkt_sent = 1'b0;
    logic        rx_pkt_rcvd = 1'b0;
    logic        bram_wea;
    logic [12:0] bram_wr_addr;
    logic [47:0] bram_wr_data;
    logic        bram_reb;
    logic [12:0] bram_rd_addr;
    logic        bram_rstb;
    logic [47:0] bram_rd_data = '0;
    logic [13:0] outstanding;
    logic        overflow_err;
    logic        underflow_err;
    logic        lat_valid;
    logic [47:0] lat_value;
    logic [47:0] lat_min;
    logic [47:0] lat_max;
    logic [63:0] lat_sum;
    logic [31:0] lat_count;

    latency_bram_ctrl dut (
        .clk(clk), .rst(rst), .latency_counter(latency_counter),
        .stats_clear(stats_clear), .tx_pkt_sent(tx_pkt_sent), .rx_pkt_rcvd(rx_pkt_rcvd),
        .bram_wea(bram_wea), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
        .bram_reb(bram_reb), .bram_rd_addr(bram_rd_addr), .bram_rstb(bram_rstb),
        .bram_rd_data(bram_rd_data), .outstanding(outstanding),
        .overflow_err(overflow_err), .underflow_err(underflow_err),
        .lat_valid(lat_valid), .lat_value(lat_value), .lat_min(lat_min),
        .lat_max(lat_max), .lat_sum(lat_sum), .lat_count(lat_count)
    );

    always #2 clk = ~clk;

    // Behavioural BRAM: data appears the cycle after the read enable.
    logic [47:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bram_wea) mem[bram_wr_addr] <= bram_wr_data;
        if (bram_reb) bram_rd_data <= mem[bram_rd_addr];
    end

    typedef struct { logic [47:0] ts; int rdy; } ent_t;
    typedef struct { logic [47:0] lat; int due; } res_t;
    ent_t q[$];
    res_t rq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [47:0] m_min, m_max;
    logic [63:0] m_sum;
    logic [31:0] m_cnt;
    logic        m_ovf, m_unf;
    int          m_wp, m_rp;
    logic        e_wea, e_reb, e_rstb;
    int          e_waddr, e_raddr;
    logic [47:0] e_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic t, input logic r, input logic [47:0] c,
                        input logic cl, input logic rs);
        bit acc_tx, acc_rx, due;
        int sz;
        ent_t e;
        res_t rr;
        logic [47:0] l;
        tx_pkt_sent = t; rx_pkt_rcvd = r; latency_counter = c;
        stats_clear = cl; rst = rs;
        e_wea = 1'b0; e_reb = 1'b0; e_rstb = cl;
        if (rs || cl) begin
            q.delete(); rq.delete();
            m_min = '1; m_max = '0; m_sum = '0; m_cnt = '0;
            m_ovf = 1'b0; m_unf = 1'b0; m_wp = 0; m_rp = 0;
        end else begin
            sz = q.size();
            acc_tx = t && (sz < DEPTH);
            acc_rx = r && (sz > 0) && (q[0].rdy <= cyc);
            if (t && !acc_tx) m_ovf = 1'b1;
            if (r && !acc_rx) m_unf = 1'b1;
            if (acc_rx) begin
                rr.lat = c - q[0].ts;
                rr.due = cyc + 3;
                rq.push_back(rr);
                void'(q.pop_front());
                e_reb = 1'b1; e_raddr = m_rp; m_rp = (m_rp + 1) % DEPTH;
            end
            if (acc_tx) begin
                e.ts = c; e.rdy = cyc + 2;
                q.push_back(e);
                e_wea = 1'b1; e_waddr = m_wp; e_wdata = c; m_wp = (m_wp + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("outstanding", 64'(outstanding), 64'(q.size()));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("underflow_err", 64'(underflow_err), 64'(m_unf));
        chk("bram_wea", 64'(bram_wea), 64'(e_wea));
        chk("bram_reb", 64'(bram_reb), 64'(e_reb));
        chk("bram_rstb", 64'(bram_rstb), 64'(e_rstb));
        if (e_wea) begin
            chk("bram_wr_addr", 64'(bram_wr_addr), 64'(e_waddr));
            chk("bram_wr_data", 64'(bram_wr_data), 64'(e_wdata));
        end
        if (e_reb) chk("bram_rd_addr", 64'(bram_rd_addr), 64'(e_raddr));
        due = (rq.size() > 0) && (rq[0].due == cyc);
        chk("lat_valid", 64'(lat_valid), 64'(due));
        if (due) begin
            l = rq[0].lat;
            void'(rq.pop_front());
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            m_sum = m_sum + {16'b0, l};
            if (l < m_min) m_min = l;
            if (l > m_max) m_max = l;
            chk("lat_value", 64'(lat_value), 64'(l));
        end
        chk("lat_min", 64'(lat_min), 64'(m_min));
        chk("lat_max", 64'(lat_max), 64'(m_max));
        chk("lat_sum", lat_sum, m_sum);
        chk("lat_count", 64'(lat_count), 64'(m_cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, latency_counter, 1'b0, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, 1'b0, latency_counter, 1'b1, 1'b0);
    endtask

    initial begin
        logic [47:0] ctr;
        // reset state
        step(1'b0, 1'b0, 48'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 48'd0, 1'b0, 1'b1);
        chk("rst_min", 64'(lat_min), 64'h0000_FFFF_FFFF_FFFF);
        chk("rst_rstb", 64'(bram_rstb), 64'd0);
        idle(2);

        // single packet, latency 37
        step(1'b1, 1'b0, 48'd100, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 48'd137, 1'b0, 1'b0);
        idle(2);
        chk("one_valid", 64'(lat_valid), 64'd1);
        chk("one_value", 64'(lat_value), 64'd37);
        chk("one_min", 64'(lat_min), 64'd37);
        chk("one_max", 64'(lat_max), 64'd37);
        chk("one_count", 64'(lat_count), 64'd1);

        // counter wrap between tx and rx
        clr();
        step(1'b1, 1'b0, 48'hFFFF_FFFF_FFF0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 48'h10, 1'b0, 1'b0);
        idle(2);
        chk("wrap_value", 64'(lat_value), 64'd32);

        // back-to-back latencies 50, 20, 80
        clr();
        step(1'b1, 1'b0, 48'd1000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 48'd1001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 48'd1002, 1'b0, 1'b0);
        step(1'b0, 1'b1, 48'd1050, 1'b0, 1'b0);
        step(1'b0, 1'b1, 48'd1021, 1'b0, 1'b0);
        step(1'b0, 1'b1, 48'd1082, 1'b0, 1'b0);
        idle(2);
        chk("b2b_min", 64'(lat_min), 64'd20);
        chk("b2b_max", 64'(lat_max), 64'd80);
        chk("b2b_sum", lat_sum, 64'd150);
        chk("b2b_count", 64'(lat_count), 64'd3);

        // underflow: rx on empty, then tx+rx together on empty
        clr();
        step(1'b0, 1'b1, 48'd5, 1'b0, 1'b0);
        chk("unf_reb0", 64'(bram_reb), 64'd0);
        step(1'b1, 1'b1, 48'd6, 1'b0, 1'b0);
        step(1'b0, 1'b0, 48'd7, 1'b0, 1'b0);
        chk("unf_reb1", 64'(bram_reb), 64'd0);
        chk("unf_flag", 64'(underflow_err), 64'd1);
        chk("unf_out", 64'(outstanding), 64'd1);

        // clear one cycle after an accepted rx discards the read
        clr();
        step(1'b1, 1'b0, 48'd200, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 48'd260, 1'b0, 1'b0);
        clr();
        chk("clr_rstb", 64'(bram_rstb), 64'd1);
        idle(3);
        chk("clr_count", 64'(lat_count), 64'd0);
        chk("clr_min", 64'(lat_min), 64'h0000_FFFF_FFFF_FFFF);

        // fill to capacity, overflow, then drain
        clr();
        ctr = 48'd5000;
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, ctr, 1'b0, 1'b0);
            ctr = ctr + 48'd1;
        end
        idle(2);
        chk("full_out", 64'(outstanding), 64'd8192);
        chk("full_ovf", 64'(overflow_err), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, ctr, 1'b0, 1'b0);
            ctr = ctr + 48'd3;
        end
        idle(3);
        chk("drain_count", 64'(lat_count), 64'd8192);
        chk("drain_out", 64'(outstanding), 64'd0);

        // randomized traffic with occasional clears, counter near wrap
        ctr = 48'hFFFF_FFFF_F000;
        for (int i = 0; i < 4000; i++) begin
            ctr = ctr + 48'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ctr,
                 ($urandom_range(0, 399) == 0), 1'b0);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/latency_bram_ctrl.md
LATENCY_BRAM_CTRL -- requirements
Module: latency_bram_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 13, meaning the timestamp BRAM address width; depth is 2^DEPTH_LOG2 = 8192.
REQ-002 SHALL have port: clk  in  1  250 MHz clock; all logic runs in this single domain.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: latency_counter  in  48  free-running timestamp counter.
REQ-005 SHALL have port: stats_clear  in  1  user clear pulse (same effect as rst, see REQ-026).
REQ-006 SHALL have port: tx_pkt_sent  in  1  single-cycle pulse: tagged packet left TX; record a timestamp.
REQ-007 SHALL have port: rx_pkt_rcvd  in  1  single-cycle pulse: echo arrived at RX; retire the oldest timestamp.
REQ-008 SHALL have ports: bram_wea out 1; bram_wr_addr out 13; bram_wr_data out 48 (BRAM write port).
REQ-009 SHALL have ports: bram_reb out 1; bram_rd_addr out 13; bram_rstb out 1; bram_rd_data in 48 (BRAM read port, 2-cycle read latency).
REQ-010 SHALL have port: outstanding  out  14  count of stored, unretired timestamps (0..8192).
REQ-011 SHALL have ports: overflow_err out 1; underflow_err out 1 (sticky error flags).
REQ-012 SHALL have ports: lat_valid out 1; lat_value out 48 (per-packet latency result).
REQ-013 SHALL have ports: lat_min out 48; lat_max out 48; lat_sum out 64; lat_count out 32 (running statistics).

Function
REQ-014 SHALL, on tx_pkt_sent with outstanding < 8192: drive bram_wea=1, bram_wr_addr=wr_ptr, bram_wr_data=latency_counter (same-cycle combinational capture), all registered so the write occurs one cycle after the pulse; wr_ptr increments mod 8192.
REQ-015 SHALL, on tx_pkt_sent with outstanding == 8192: perform no write, leave wr_ptr unchanged and set overflow_err.
REQ-016 SHALL, on rx_pkt_rcvd with outstanding > 0: assert bram_reb=1 with bram_rd_addr=rd_ptr one cycle after the pulse, capture latency_counter in that issue cycle, and increment rd_ptr mod 8192.
REQ-017 SHALL, on rx_pkt_rcvd with outstanding == 0: perform no read and set underflow_err.
REQ-018 SHALL update outstanding on the write/read issue edge: +1 for a write only, -1 for a read only, unchanged when both occur in the same cycle.
REQ-019 SHALL make an entry readable no earlier than the cycle after its BRAM write; rx_pkt_rcvd sampled while the only entry is still in the write register SHALL be treated as empty (REQ-017).
REQ-020 SHALL carry a valid/timestamp shift pipeline matching the 2-cycle BRAM latency, and assert lat_valid exactly 3 cycles after the accepted rx_pkt_rcvd, for 1 cycle.
REQ-021 SHALL compute lat_value = captured_counter - bram_rd_data modulo 2^48, so a counter wrap yields the correct positive difference.
REQ-022 SHALL, on each lat_valid: increment lat_count (saturate at 2^32-1); add lat_value to lat_sum (wraps at 2^64); set lat_min = min(lat_min, lat_value); set lat_max = max(lat_max, lat_value).
REQ-023 SHALL accept back-to-back pulses every cycle on both ports and keep full throughput, i.e. one write and one read per cycle.
REQ-024 SHALL keep overflow_err and underflow_err set until rst or stats_clear.

Reset
REQ-025 SHALL, on rst, set: wr_ptr=0, rd_ptr=0, outstanding=0, bram_wea=0, bram_reb=0, bram_wr_addr=0, bram_rd_addr=0, bram_wr_data=0, lat_valid=0, lat_value=0, lat_min=48'hFFFF_FFFF_FFFF, lat_max=0, lat_sum=0, lat_count=0, both error flags=0, pipeline valids=0.
REQ-026 SHALL treat stats_clear identically to rst, and additionally assert bram_rstb for exactly 1 cycle.
REQ-027 SHALL give rst/stats_clear priority over tx_pkt_sent and rx_pkt_rcvd in the same cycle; those pulses are dropped and no error flag is set.
REQ-028 SHALL discard in-flight reads on rst or stats_clear, so no lat_valid occurs for reads issued before the clear.

Verification
REQ-029 SHALL cover: counter=100, tx; counter=137, rx -> cycle+3 lat_valid=1, lat_value=37, lat_min=lat_max=37, lat_count=1.
REQ-030 SHALL cover: counter=48'hFFFF_FFFF_FFF0 at tx, 48'h10 at rx -> lat_value=32.
REQ-031 SHALL cover: 8192 tx, one more tx -> outstanding=8192, no 8193rd write, overflow_err=1; then 8192 rx -> lat_count=8192, outstanding=0, addresses wrap 8191->0.
REQ-032 SHALL cover: rx with outstanding=0, and tx+rx in the same cycle with outstanding=0 -> no bram_reb, underflow_err=1, outstanding ends at 1.
REQ-033 SHALL cover: stats_clear 1 cycle after an accepted rx -> no lat_valid, bram_rstb pulses 1 cycle, all statistics at reset values.
REQ-034 SHALL cover: latencies 50, 20, 80 back-to-back -> lat_min=20, lat_max=80, lat_sum=150, lat_count=3.
